// File: rtl/ratio_accumulator.sv
// ratio_accumulator
//   Feeds the 16-bit iterative divider in the lock datapath. Box-car averages
//   a signed error channel (A) and an unsigned normalisation channel (B) over
//   2^log2_n samples. Each completed window launches one divide with
//   numerator = mean A and denominator = mean B. The quotient is captured
//   into a held result register.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   sample_valid one-cycle strobe, ch_a/ch_b valid this cycle
//   ch_a         signed 16-bit numerator sample
//   ch_b         unsigned 16-bit denominator sample
//   log2_n       window length exponent, latched at each window start
//   shift_cfg    divider mode/shift, latched with each launch
//   div_once     one-cycle divider start pulse
//   div_in0      numerator operand (signed mean A), held while busy
//   div_in1      denominator operand (unsigned mean B), held while busy
//   div_shift    divider shift, held while busy
//   div_done     one-cycle divider completion pulse
//   div_out      divider quotient, valid with div_done
//   result       last captured quotient
//   result_valid one-cycle pulse, the cycle after an accepted div_done
//   overrun      one-cycle pulse, a window closed while the divider was busy
//   div_zero     one-cycle pulse, mean B was zero so the launch was skipped

module ratio_accumulator #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] ch_a,
  input  logic [15:0] ch_b,
  input  logic [3:0]  log2_n,
  input  logic [3:0]  shift_cfg,
  output logic        div_once,
  output logic [15:0] div_in0,
  output logic [15:0] div_in1,
  output logic [3:0]  div_shift,
  input  logic        div_done,
  input  logic [15:0] div_out,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        overrun,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0] acc_a;
  logic        [ACC_W-1:0] acc_b;
  logic        [14:0]      cnt;
  logic        [3:0]       win_log2;

  logic        [3:0]       eff_log2;
  logic        [14:0]      last_idx;
  logic                    win_close;
  logic signed [ACC_W-1:0] sum_a;
  logic        [ACC_W-1:0] sum_b;
  logic        [15:0]      mean_a;
  logic        [15:0]      mean_b;
  logic                    mean_ok;

  logic        launch_new;
  logic        launch_pend;
  logic        zero_now;
  logic        overrun_now;
  logic        capture_now;
  logic        pend_set;

  logic        pend;
  logic [15:0] pend_a;
  logic [15:0] pend_b;

  // The first sample of a window uses the live log2_n, since that is the
  // value being latched for the window; later samples use the latched copy.
  assign eff_log2  = (cnt == 15'd0) ? log2_n : win_log2;
  assign last_idx  = 15'((16'd1 << eff_log2) - 16'd1);
  assign win_close = sample_valid && (cnt == last_idx);

  // Sums include the current sample so the closing sample counts toward the
  // means. The means are taken in the same cycle and registered by the
  // launch logic, so the accumulators can clear at once and a strobe on the
  // very next cycle starts the new window without losing a sample.
  assign sum_a   = acc_a + {{(ACC_W-16){ch_a[15]}}, ch_a};
  assign sum_b   = acc_b + {{(ACC_W-16){1'b0}}, ch_b};
  assign mean_a  = 16'(sum_a >>> eff_log2);
  assign mean_b  = 16'(sum_b >> eff_log2);
  assign mean_ok = (mean_b != 16'd0);

  // Window accumulation. The divider never stalls this path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a    <= '0;
      acc_b    <= '0;
      cnt      <= '0;
      win_log2 <= '0;
    end else if (sample_valid) begin
      if (cnt == 15'd0) begin
        win_log2 <= log2_n;
      end
      if (win_close) begin
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        cnt   <= cnt + 15'd1;
      end
    end
  end

  // Divider handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state. A pending launch always goes straight to BUSY.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pend || (win_close && mean_ok)) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (div_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = pend ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-cycle decisions. A close that arrives while the divider cannot take
  // a new operand set this cycle or next is deferred through the pending
  // flag. That happens when the close lands in DONE or together with
  // div_done. Any other close that finds the divider committed is an overrun.
  always_comb begin
    launch_new   = 1'b0;
    launch_pend  = 1'b0;
    zero_now     = 1'b0;
    overrun_now  = 1'b0;
    capture_now  = 1'b0;
    pend_set     = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          launch_pend = 1'b1;
          overrun_now = win_close;
        end else if (win_close) begin
          launch_new = mean_ok;
          zero_now   = !mean_ok;
        end
      end
      BUSY: begin
        if (div_done) begin
          capture_now = 1'b1;
          if (win_close) begin
            pend_set = mean_ok;
            zero_now = !mean_ok;
          end
        end else begin
          overrun_now = win_close;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (pend) begin
          launch_pend = 1'b1;
          overrun_now = win_close;
        end else if (win_close) begin
          pend_set = mean_ok;
          zero_now = !mean_ok;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered pulses, operands, captured quotient and the pending launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_once  <= 1'b0;
      div_zero  <= 1'b0;
      overrun   <= 1'b0;
      div_in0   <= '0;
      div_in1   <= '0;
      div_shift <= '0;
      result    <= '0;
      pend      <= 1'b0;
      pend_a    <= '0;
      pend_b    <= '0;
    end else begin
      div_once <= launch_new | launch_pend;
      div_zero <= zero_now;
      overrun  <= overrun_now;
      if (launch_new) begin
        div_in0   <= mean_a;
        div_in1   <= mean_b;
        div_shift <= shift_cfg;
      end else if (launch_pend) begin
        div_in0   <= pend_a;
        div_in1   <= pend_b;
        div_shift <= shift_cfg;
      end
      if (capture_now) begin
        result <= div_out;
      end
      if (pend_set) begin
        pend   <= 1'b1;
        pend_a <= mean_a;
        pend_b <= mean_b;
      end else if (launch_pend) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ratio_accumulator.sv
// tb_ratio_accumulator
//   Self-checking bench for ratio_accumulator. Directed steps follow the
//   feature list, then a randomized stretch with a bench-side divider.
//   The reference model keeps window sums as plain integers and takes means
//   by floor division. The divider side is tracked as busy / result-due /
//   queued-launch flags.

module tb_ratio_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] ch_a;
  logic [15:0] ch_b;
  logic [3:0]  log2_n;
  logic [3:0]  shift_cfg;
  logic        div_once;
  logic [15:0] div_in0;
  logic [15:0] div_in1;
  logic [3:0]  div_shift;
  logic        div_done;
  logic [15:0] div_out;
  logic [15:0] result;
  logic        result_valid;
  logic        overrun;
  logic        div_zero;

  ratio_accumulator #(.ACC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .ch_a         (ch_a),
    .ch_b         (ch_b),
    .log2_n       (log2_n),
    .shift_cfg    (shift_cfg),
    .div_once     (div_once),
    .div_in0      (div_in0),
    .div_in1      (div_in1),
    .div_shift    (div_shift),
    .div_done     (div_done),
    .div_out      (div_out),
    .result       (result),
    .result_valid (result_valid),
    .overrun      (overrun),
    .div_zero     (div_zero)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state.
  int          m_cnt;
  int          m_win;
  longint      m_sum_a;
  longint      m_sum_b;
  bit          m_busy;
  bit          m_queued;
  logic [15:0] m_qa;
  logic [15:0] m_qb;

  // Expected outputs for the cycle after the latest edge.
  logic        e_once;
  logic        e_zero;
  logic        e_ovr;
  logic        e_rv;
  logic [15:0] e_in0;
  logic [15:0] e_in1;
  logic [3:0]  e_shift;
  logic [15:0] e_result;

  int div_wait;

  // Floor division, so negative sums round toward minus infinity.
  function automatic longint floorDiv(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    m_cnt    = 0;
    m_win    = 0;
    m_sum_a  = 0;
    m_sum_b  = 0;
    m_busy   = 0;
    m_queued = 0;
    m_qa     = 16'd0;
    m_qb     = 16'd0;
    e_once   = 1'b0;
    e_zero   = 1'b0;
    e_ovr    = 1'b0;
    e_rv     = 1'b0;
    e_in0    = 16'd0;
    e_in1    = 16'd0;
    e_shift  = 4'd0;
    e_result = 16'd0;
  endtask

  task automatic startDivide(input logic [15:0] a, input logic [15:0] b);
    e_once  = 1'b1;
    e_in0   = a;
    e_in1   = b;
    e_shift = shift_cfg;
    m_busy  = 1;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelEdge();
    bit          close;
    bit          rv_now;
    logic [15:0] ma;
    logic [15:0] mb;
    longint      n;
    close  = 0;
    ma     = 16'd0;
    mb     = 16'd0;
    rv_now = e_rv;
    e_once = 1'b0;
    e_zero = 1'b0;
    e_ovr  = 1'b0;
    e_rv   = 1'b0;
    if (sample_valid) begin
      if (m_cnt == 0) m_win = int'(log2_n);
      m_sum_a += longint'($signed(ch_a));
      m_sum_b += longint'(ch_b);
      m_cnt++;
      if (m_cnt == (1 << m_win)) begin
        n       = longint'(1) << m_win;
        close   = 1;
        ma      = 16'(floorDiv(m_sum_a, n));
        mb      = 16'(m_sum_b / n);
        m_cnt   = 0;
        m_sum_a = 0;
        m_sum_b = 0;
      end
    end
    if (m_busy && div_done) begin
      e_result = div_out;
      e_rv     = 1'b1;
      m_busy   = 0;
      if (close) begin
        if (mb != 16'd0) begin
          m_queued = 1;
          m_qa     = ma;
          m_qb     = mb;
        end else begin
          e_zero = 1'b1;
        end
      end
    end else if (m_busy) begin
      if (close) e_ovr = 1'b1;
    end else if (m_queued) begin
      startDivide(m_qa, m_qb);
      m_queued = 0;
      if (close) e_ovr = 1'b1;
    end else if (close) begin
      if (mb == 16'd0) begin
        e_zero = 1'b1;
      end else if (rv_now) begin
        m_queued = 1;
        m_qa     = ma;
        m_qb     = mb;
      end else begin
        startDivide(ma, mb);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " div_once"},     16'(div_once),     16'(e_once));
    checkOutput({tag, " div_zero"},     16'(div_zero),     16'(e_zero));
    checkOutput({tag, " overrun"},      16'(overrun),      16'(e_ovr));
    checkOutput({tag, " result_valid"}, 16'(result_valid), 16'(e_rv));
    checkOutput({tag, " div_in0"},      div_in0,           e_in0);
    checkOutput({tag, " div_in1"},      div_in1,           e_in1);
    checkOutput({tag, " div_shift"},    16'(div_shift),    16'(e_shift));
    checkOutput({tag, " result"},       result,            e_result);
  endtask

  // Drive one cycle of inputs, step the model at the edge, check just after.
  task automatic applyStimulus(input string tag, input logic sv, input logic [15:0] a,
                               input logic [15:0] b, input logic dd, input logic [15:0] dout);
    sample_valid = sv;
    ch_a         = a;
    ch_b         = b;
    div_done     = dd;
    div_out      = dout;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0);
  endtask

  // Reset is asynchronous: outputs must clear before any clock edge.
  task automatic doReset(input string tag);
    sample_valid = 1'b0;
    div_done     = 1'b0;
    rst          = 1'b1;
    #1;
    modelReset();
    checkAll({tag, " async"});
    @(posedge clk);
    #1;
    checkAll({tag, " held"});
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic dd;
    logic [15:0] b;

    rst          = 1'b1;
    sample_valid = 1'b0;
    ch_a         = 16'd0;
    ch_b         = 16'd0;
    log2_n       = 4'd0;
    shift_cfg    = 4'd0;
    div_done     = 1'b0;
    div_out      = 16'd0;
    div_wait     = 0;
    modelReset();
    @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    $display("[TB] basic window of 4");
    log2_n    = 4'd2;
    shift_cfg = 4'd3;
    applyStimulus("t1 s0", 1'b1, 16'd100,   16'd1000, 1'b0, 16'd0);
    applyStimulus("t1 s1", 1'b1, 16'd200,   16'd1000, 1'b0, 16'd0);
    applyStimulus("t1 s2", 1'b1, 16'hFFCE,  16'd1000, 1'b0, 16'd0);
    applyStimulus("t1 s3", 1'b1, 16'hFFF6,  16'd1000, 1'b0, 16'd0);
    checkOutput("t1 once const", 16'(div_once), 16'd1);
    checkOutput("t1 in0 const", div_in0, 16'd60);
    checkOutput("t1 in1 const", div_in1, 16'd1000);
    idle("t1 wait", 2);
    applyStimulus("t1 done", 1'b0, 16'd0, 16'd0, 1'b1, 16'h1234);
    checkOutput("t1 result const", result, 16'h1234);
    checkOutput("t1 rv const", 16'(result_valid), 16'd1);
    idle("t1 tail", 2);

    $display("[TB] negative mean floors");
    log2_n = 4'd1;
    applyStimulus("t2 s0", 1'b1, 16'hFFFD, 16'd5, 1'b0, 16'd0);
    applyStimulus("t2 s1", 1'b1, 16'hFFFE, 16'd6, 1'b0, 16'd0);
    checkOutput("t2 in0 const", div_in0, 16'hFFFD);
    checkOutput("t2 in1 const", div_in1, 16'd5);
    idle("t2 wait", 1);
    applyStimulus("t2 done", 1'b0, 16'd0, 16'd0, 1'b1, 16'h0042);
    idle("t2 tail", 2);

    $display("[TB] overrun while busy");
    log2_n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("t3 strobe", 1'b1, 16'(i * 100 - 300), 16'(i + 1), 1'b0, 16'd0);
    end
    checkOutput("t3 in0 held const", div_in0, 16'hFED4);
    applyStimulus("t3 coincide", 1'b1, 16'd777, 16'd9, 1'b1, 16'h5555);
    checkOutput("t3 no overrun const", 16'(overrun), 16'd0);
    idle("t3 wait", 3);
    applyStimulus("t3 done", 1'b0, 16'd0, 16'd0, 1'b1, 16'h6666);
    idle("t3 tail", 2);

    $display("[TB] zero denominator");
    log2_n = 4'd1;
    applyStimulus("t4 s0", 1'b1, 16'd7, 16'd0, 1'b0, 16'd0);
    applyStimulus("t4 s1", 1'b1, 16'd9, 16'd0, 1'b0, 16'd0);
    checkOutput("t4 zero const", 16'(div_zero), 16'd1);
    checkOutput("t4 once const", 16'(div_once), 16'd0);
    checkOutput("t4 result const", result, 16'h6666);
    idle("t4 tail", 2);

    $display("[TB] close coincident with done");
    applyStimulus("t5 s0", 1'b1, 16'd10, 16'd20, 1'b0, 16'd0);
    applyStimulus("t5 s1", 1'b1, 16'd30, 16'd40, 1'b0, 16'd0);
    idle("t5 wait", 1);
    applyStimulus("t5 s2", 1'b1, 16'hFFF8, 16'd100, 1'b0, 16'd0);
    applyStimulus("t5 close", 1'b1, 16'hFFFC, 16'd300, 1'b1, 16'hBEEF);
    checkOutput("t5 result const", result, 16'hBEEF);
    checkOutput("t5 overrun const", 16'(overrun), 16'd0);
    checkOutput("t5 once early const", 16'(div_once), 16'd0);
    idle("t5 gap", 1);
    checkOutput("t5 once const", 16'(div_once), 16'd1);
    checkOutput("t5 in0 const", div_in0, 16'hFFFA);
    checkOutput("t5 in1 const", div_in1, 16'd200);
    idle("t5 wait2", 2);
    applyStimulus("t5 done", 1'b0, 16'd0, 16'd0, 1'b1, 16'h0101);
    idle("t5 tail", 2);

    $display("[TB] reset mid-window and mid-busy");
    log2_n = 4'd1;
    applyStimulus("t6 s0", 1'b1, 16'd5, 16'd5, 1'b0, 16'd0);
    doReset("t6 rst window");
    log2_n = 4'd0;
    applyStimulus("t6 s1", 1'b1, 16'd40, 16'd8, 1'b0, 16'd0);
    checkOutput("t6 once const", 16'(div_once), 16'd1);
    checkOutput("t6 in0 const", div_in0, 16'd40);
    idle("t6 wait", 1);
    doReset("t6 rst busy");
    applyStimulus("t6 s2", 1'b1, 16'd12, 16'd3, 1'b0, 16'd0);
    checkOutput("t6 relaunch const", 16'(div_once), 16'd1);
    idle("t6 wait2", 1);
    applyStimulus("t6 done", 1'b0, 16'd0, 16'd0, 1'b1, 16'h0099);
    idle("t6 tail", 2);

    $display("[TB] randomized traffic");
    div_wait = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) log2_n = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) shift_cfg = 4'($urandom);
      if (div_wait > 0) begin
        div_wait--;
        dd = (div_wait == 0);
      end else begin
        dd = (!m_busy && $urandom_range(0, 15) == 0);
      end
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      applyStimulus("rand", ($urandom_range(0, 9) < 6), 16'($urandom), b, dd, 16'($urandom));
      if (e_once) div_wait = $urandom_range(2, 6);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus("drain", 1'b0, 16'd0, 16'd0, m_busy, 16'h0F0F);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
